data_memory_sync: RTL and testbench

Parametrised, clocked successor to the team's word-addressed data memory. It has independent read and write ports, per-byte write enables and a registered read with one-cycle latency. Same-address read/write collisions are handled deterministically, and a hardware zero-fill sequence runs after every reset. It sits in the MEM stage of the processor datapath and is driven by the pipeline's MEM control signals.

---
 rtl/data_memory_sync_if.sv | 28 ++
 rtl/data_memory_sync.sv | 122 ++++++++++++
 tb/tb_data_memory_sync.sv | 170 +++++++++++++++++
 3 files changed

// File: rtl/data_memory_sync_if.sv
// MEM-stage bus between the pipeline and data_memory_sync: read port, write port
// with byte enables, and the Ready/ReadValid status returned by the memory.
interface data_memory_sync_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 8
);
  localparam int NB = DATA_WIDTH / 8;

  logic                  Ready;
  logic                  ReadEnable;
  logic [ADDR_WIDTH-1:0] ReadAddress;
  logic [DATA_WIDTH-1:0] ReadData;
  logic                  ReadValid;
  logic                  WriteEnable;
  logic [ADDR_WIDTH-1:0] WriteAddress;
  logic [DATA_WIDTH-1:0] WriteData;
  logic [NB-1:0]         WriteByteEn;

  modport master (
    input  Ready, ReadData, ReadValid,
    output ReadEnable, ReadAddress, WriteEnable, WriteAddress, WriteData, WriteByteEn
  );

  modport slave (
    output Ready, ReadData, ReadValid,
    input  ReadEnable, ReadAddress, WriteEnable, WriteAddress, WriteData, WriteByteEn
  );
endinterface

// File: rtl/data_memory_sync.sv
// Word-addressed data memory with byte-lane writes, 1-cycle registered read,
// write-first collision forwarding and a zero-fill sweep after every reset.

// One byte lane: its own storage slice plus the registered read byte.
module data_memory_sync_lane #(
  parameter int ADDR_WIDTH = 8
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  wr_en_i,
  input  logic [ADDR_WIDTH-1:0] wr_addr_i,
  input  logic [7:0]            wr_byte_i,
  input  logic                  rd_en_i,
  input  logic [ADDR_WIDTH-1:0] rd_addr_i,
  output logic [7:0]            rd_byte_o
);
  localparam int DEPTH = 1 << ADDR_WIDTH;

  logic [7:0] mem_q [DEPTH];
  logic [7:0] rd_d, rd_q;

  // Storage is deliberately not reset; the zero-fill sweep clears it.
  always_ff @(posedge clk_i) begin
    if (wr_en_i) mem_q[wr_addr_i] <= wr_byte_i;
  end

  // Write-first: a same-edge write to the read address is forwarded.
  always_comb begin
    rd_d = mem_q[rd_addr_i];
    if (wr_en_i && (wr_addr_i == rd_addr_i)) rd_d = wr_byte_i;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)      rd_q <= '0;
    else if (rd_en_i) rd_q <= rd_d;
  end

  assign rd_byte_o = rd_q;
endmodule

module data_memory_sync #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 8
) (
  input  logic               Clock,
  input  logic               ResetN,
  data_memory_sync_if.slave  mem
);
  localparam int NB    = DATA_WIDTH / 8;
  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam int CW    = ADDR_WIDTH + 1;

  typedef enum logic {INIT, RUN} state_e;

  state_e                 state_q, state_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic [1:0]             vld_pipe_q;
  logic                   rd_fire;
  logic [ADDR_WIDTH-1:0]  wr_addr;
  logic [DATA_WIDTH-1:0]  wr_data;
  logic [NB-1:0]          wr_lane;
  logic [NB-1:0][7:0]     rd_data;

  always_ff @(posedge Clock or negedge ResetN) begin
    if (!ResetN) begin
      state_q <= INIT;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // INIT owns the write port (all lanes, zero data); ports are gated until RUN.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    wr_addr = mem.WriteAddress;
    wr_data = mem.WriteData;
    wr_lane = '0;
    rd_fire = 1'b0;
    case (state_q)
      INIT: begin
        wr_addr = cnt_q[ADDR_WIDTH-1:0];
        wr_data = '0;
        wr_lane = '1;
        cnt_d   = cnt_q + CW'(1);
        if (cnt_q == CW'(DEPTH - 1)) state_d = RUN;
      end
      RUN: begin
        wr_lane = mem.WriteEnable ? mem.WriteByteEn : '0;
        rd_fire = mem.ReadEnable;
      end
      default: state_d = INIT;
    endcase
  end

  for (genvar i = 0; i < NB; i++) begin : g_lane
    data_memory_sync_lane #(.ADDR_WIDTH(ADDR_WIDTH)) u_lane (
      .clk_i     (Clock),
      .rst_ni    (ResetN),
      .wr_en_i   (wr_lane[i]),
      .wr_addr_i (wr_addr),
      .wr_byte_i (wr_data[8*i +: 8]),
      .rd_en_i   (rd_fire),
      .rd_addr_i (mem.ReadAddress),
      .rd_byte_o (rd_data[i])
    );
  end

  always_ff @(posedge Clock or negedge ResetN) begin
    if (!ResetN) vld_pipe_q <= '0;
    else         vld_pipe_q <= {vld_pipe_q[0], rd_fire};
  end

  assign mem.ReadData  = rd_data;
  assign mem.ReadValid = vld_pipe_q[0];
  assign mem.Ready     = (state_q == RUN);

  logic unused_vld;
  assign unused_vld = vld_pipe_q[1];
endmodule

// File: tb/tb_data_memory_sync.sv
// Directed bench for data_memory_sync: fill timing, port gating, byte lanes,
// write-first collisions, hold behaviour and reset in the middle of operation.
module tb_data_memory_sync;
  localparam int DW = 32;
  localparam int AW = 8;
  localparam int DEPTH = 1 << AW;

  logic Clock = 1'b0;
  logic ResetN = 1'b0;
  int total = 0;
  int bad = 0;

  data_memory_sync_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

  data_memory_sync #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .Clock  (Clock),
    .ResetN (ResetN),
    .mem    (bus)
  );

  always #5 Clock = ~Clock;

  task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance one edge; inputs change and outputs are sampled 1 time unit after it.
  task automatic step();
    @(posedge Clock);
    #1;
  endtask

  task automatic idle();
    bus.ReadEnable   = 1'b0;
    bus.ReadAddress  = '0;
    bus.WriteEnable  = 1'b0;
    bus.WriteAddress = '0;
    bus.WriteData    = '0;
    bus.WriteByteEn  = '0;
  endtask

  task automatic wr(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [3:0] be);
    bus.WriteEnable  = 1'b1;
    bus.WriteAddress = a;
    bus.WriteData    = d;
    bus.WriteByteEn  = be;
    step();
    bus.WriteEnable  = 1'b0;
  endtask

  task automatic rd(input string tag, input logic [AW-1:0] a, input logic [DW-1:0] exp);
    bus.ReadEnable  = 1'b1;
    bus.ReadAddress = a;
    step();
    bus.ReadEnable  = 1'b0;
    check({tag, "_valid"}, {31'b0, bus.ReadValid}, 32'd1);
    check({tag, "_data"}, bus.ReadData, exp);
  endtask

  // Counts edges from reset release; Ready must be low through edge DEPTH-1, high after DEPTH.
  task automatic fill_wait(input string tag, input bit gate_ports);
    int ready_early = 0;
    int vld_seen = 0;
    for (int c = 1; c <= DEPTH; c++) begin
      step();
      if (c < DEPTH && bus.Ready !== 1'b0) ready_early++;
      if (bus.ReadValid !== 1'b0) vld_seen++;
    end
    check({tag, "_ready_early"}, 32'(ready_early), 32'd0);
    check({tag, "_ready"}, {31'b0, bus.Ready}, 32'd1);
    if (gate_ports) check({tag, "_init_readvalid"}, 32'(vld_seen), 32'd0);
  endtask

  initial begin
    logic [DW-1:0] held;
    idle();
    #1;
    check("rst_ready", {31'b0, bus.Ready}, 32'd0);
    check("rst_valid", {31'b0, bus.ReadValid}, 32'd0);
    check("rst_data", bus.ReadData, 32'd0);
    step();
    step();
    check("rst_hold_ready", {31'b0, bus.Ready}, 32'd0);

    // Release reset and hammer both ports throughout the sweep.
    ResetN = 1'b1;
    bus.WriteEnable  = 1'b1;
    bus.WriteAddress = 8'h05;
    bus.WriteData    = 32'hFFFF_FFFF;
    bus.WriteByteEn  = 4'hF;
    bus.ReadEnable   = 1'b1;
    bus.ReadAddress  = 8'h05;
    fill_wait("fill", 1'b1);
    idle();
    step();
    check("run_idle_valid", {31'b0, bus.ReadValid}, 32'd0);

    rd("fill_rd00", 8'h00, 32'h0);
    rd("fill_rd7f", 8'h7F, 32'h0);
    rd("fill_rdff", 8'hFF, 32'h0);
    rd("gate_rd05", 8'h05, 32'h0);

    wr(8'h10, 32'hDEAD_BEEF, 4'hF);
    rd("full_rd10", 8'h10, 32'hDEAD_BEEF);
    step();
    check("hold_valid", {31'b0, bus.ReadValid}, 32'd0);
    check("hold_data", bus.ReadData, 32'hDEAD_BEEF);

    wr(8'h10, 32'h1122_3344, 4'b0101);
    rd("lane_rd10", 8'h10, 32'hDE22_BE44);
    wr(8'h10, 32'h0000_0000, 4'b0000);
    rd("be0_rd10", 8'h10, 32'hDE22_BE44);

    wr(8'h20, 32'h1234_5678, 4'hF);
    wr(8'h21, 32'h9ABC_DEF0, 4'hF);
    // Same-address collision: upper lanes forwarded, lower lanes from storage.
    bus.WriteEnable  = 1'b1;
    bus.WriteAddress = 8'h20;
    bus.WriteData    = 32'hCAFE_F00D;
    bus.WriteByteEn  = 4'b1100;
    rd("coll_same", 8'h20, 32'hCAFE_5678);
    idle();
    // Different-address read alongside a write.
    bus.WriteEnable  = 1'b1;
    bus.WriteAddress = 8'h20;
    bus.WriteData    = 32'h5555_5555;
    bus.WriteByteEn  = 4'b0001;
    rd("coll_diff", 8'h21, 32'h9ABC_DEF0);
    idle();
    rd("coll_post", 8'h20, 32'hCAFE_5655);

    // Back-to-back reads, one per edge.
    bus.ReadEnable  = 1'b1;
    bus.ReadAddress = 8'h10;
    step();
    check("b2b_0_data", bus.ReadData, 32'hDE22_BE44);
    bus.ReadAddress = 8'h21;
    step();
    check("b2b_1_valid", {31'b0, bus.ReadValid}, 32'd1);
    check("b2b_1_data", bus.ReadData, 32'h9ABC_DEF0);
    idle();

    wr(8'h30, 32'hA5A5_A5A5, 4'hF);
    rd("pre_rst_rd30", 8'h30, 32'hA5A5_A5A5);
    held = bus.ReadData;
    check("pre_rst_held", held, 32'hA5A5_A5A5);
    bus.ReadEnable  = 1'b1;
    bus.ReadAddress = 8'h30;
    #2;
    ResetN = 1'b0;
    #1;
    check("midrst_ready", {31'b0, bus.Ready}, 32'd0);
    check("midrst_valid", {31'b0, bus.ReadValid}, 32'd0);
    check("midrst_data", bus.ReadData, 32'd0);
    step();
    check("midrst_edge_valid", {31'b0, bus.ReadValid}, 32'd0);
    idle();
    ResetN = 1'b1;
    fill_wait("refill", 1'b0);
    rd("refill_rd30", 8'h30, 32'h0);
    rd("refill_rd10", 8'h10, 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
